// File: rtl/riscv_mc_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_mc_ctrl
//
// Multicycle control FSM for the single-issue RV32I core. It steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB over the shared ALU
// datapath. It drives the operand-2 select, the register-file write, the PC
// update and the instruction/data memory request handshakes.
//
// All outputs are registered. Strobes (rf_we, pc_we, retire) are high during
// the cycle of the state that performs them:
//   - ALU / JAL / JALR / LUI / AUIPC / LOAD : during WB.
//   - BRANCH : during EXEC. br_taken is sampled at the end of DECODE, when
//     the register operands read from ir are already valid.
//   - STORE  : during the first FETCH cycle after mem_ack. A registered
//     output cannot pulse in the same cycle as the ack that causes it.
//
// op2_sel encoding (mirrors OP2_SEL in riscv_constants.sv):
//   0 = OP2_RS2, 1 = OP2_IMI, 2 = OP2_IMS, 3 = OP2_IMJ, 4 = OP2_IMU
//
// Optional feature, macro RISCV_CTRL_TIMEOUT_EN:
//   - Defined: a wait counter of 8..32 bits counts cycles in which a request
//     is outstanding and no ack arrives. After TIMEOUT_CYCLES unanswered
//     cycles the request drops, the FSM halts and bus_err is set.
//   - Undefined: handshakes wait forever. The bus_err register only ever
//     loads 0, so it folds to a constant.
//
// Ports:
//   clk, rst_n             core clock, asynchronous active-low reset
//   inst_req/inst_ack/inst instruction fetch handshake and fetched word
//   mem_req/mem_we/mem_ack data memory handshake (mem_we=1 for stores)
//   br_taken               branch comparator result
//   op2_sel                ALU operand-2 select
//   rf_we                  register-file write strobe
//   wb_sel                 0=ALU, 1=mem rdata, 2=PC+4
//   pc_we                  PC update strobe
//   pc_sel                 0=PC+4, 1=PC+imm, 2=ALU (JALR)
//   ir                     latched instruction
//   retire, instret        retire pulse and retired-instruction count
//   halted, illegal,       halt status: halted, halted on an unknown
//   bus_err                opcode, halted on a handshake timeout
// -----------------------------------------------------------------------------
module riscv_mc_ctrl #(
  parameter int WORD_LENGTH    = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   inst_req,
  input  logic                   inst_ack,
  input  logic [WORD_LENGTH-1:0] inst,
  output logic                   mem_req,
  output logic                   mem_we,
  input  logic                   mem_ack,
  input  logic                   br_taken,
  output logic [2:0]             op2_sel,
  output logic                   rf_we,
  output logic [1:0]             wb_sel,
  output logic                   pc_we,
  output logic [1:0]             pc_sel,
  output logic [WORD_LENGTH-1:0] ir,
  output logic                   retire,
  output logic [CNT_WIDTH-1:0]   instret,
  output logic                   halted,
  output logic                   illegal,
  output logic                   bus_err
);

  localparam logic [2:0] OP2_RS2 = 3'd0;
  localparam logic [2:0] OP2_IMI = 3'd1;
  localparam logic [2:0] OP2_IMS = 3'd2;
  localparam logic [2:0] OP2_IMJ = 3'd3;
  localparam logic [2:0] OP2_IMU = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [WORD_LENGTH-1:0] ECALL_WORD = WORD_LENGTH'(32'h0000_0073);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic                   inst_req_q, inst_req_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic                   rf_we_q, rf_we_d;
  logic                   pc_we_q, pc_we_d;
  logic                   retire_q, retire_d;
  logic                   halted_q, halted_d;
  logic                   illegal_q, illegal_d;
  logic                   bus_err_q, bus_err_d;
  logic [2:0]             op2_sel_q, op2_sel_d;
  logic [1:0]             wb_sel_q, wb_sel_d;
  logic [1:0]             pc_sel_q, pc_sel_d;
  logic [WORD_LENGTH-1:0] ir_q, ir_d;
  logic [CNT_WIDTH-1:0]   instret_q, instret_d;

  logic [6:0] opcode;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       wait_expired;

  // The instruction class is taken from ir, which holds until the next
  // fetch. EXEC and MEM therefore need no separate class register.
  assign opcode    = ir_q[6:0];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

`ifdef RISCV_CTRL_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 32) ? 32 : TO_RAW);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

  // The counter counts each unanswered request cycle. It falls back to 0 as
  // soon as an ack arrives or the FSM leaves the waiting states.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == S_FETCH && !inst_ack) || (state_q == S_MEM && !mem_ack)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // True in the last allowed waiting cycle. A concurrent ack still wins.
  assign wait_expired = (wait_cnt_q == TO_LAST);
`else
  assign wait_expired = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    inst_req_d = 1'b0;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    rf_we_d    = 1'b0;
    pc_we_d    = 1'b0;
    retire_d   = 1'b0;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    op2_sel_d  = op2_sel_q;
    wb_sel_d   = wb_sel_q;
    pc_sel_d   = pc_sel_q;
    ir_d       = ir_q;
    instret_d  = instret_q;

    unique case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        inst_req_d = 1'b1;
      end

      S_FETCH: begin
        if (inst_ack) begin
          ir_d    = inst;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          inst_req_d = 1'b1;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          OPC_OP: begin
            op2_sel_d = OP2_RS2; wb_sel_d = WB_ALU; pc_sel_d = PC_PLUS4;
          end
          OPC_OPIMM: begin
            op2_sel_d = OP2_IMI; wb_sel_d = WB_ALU; pc_sel_d = PC_PLUS4;
          end
          OPC_LOAD: begin
            op2_sel_d = OP2_IMI; wb_sel_d = WB_MEM; pc_sel_d = PC_PLUS4;
          end
          OPC_STORE: begin
            op2_sel_d = OP2_IMS; wb_sel_d = WB_ALU; pc_sel_d = PC_PLUS4;
          end
          OPC_BRANCH: begin
            // The branch resolves here, so its PC strobe and retire
            // appear during EXEC.
            op2_sel_d = OP2_RS2;
            wb_sel_d  = WB_ALU;
            pc_sel_d  = br_taken ? PC_IMM : PC_PLUS4;
            pc_we_d   = 1'b1;
            retire_d  = 1'b1;
            instret_d = instret_q + CNT_ONE;
          end
          OPC_JAL: begin
            op2_sel_d = OP2_IMJ; wb_sel_d = WB_PC4; pc_sel_d = PC_IMM;
          end
          OPC_JALR: begin
            op2_sel_d = OP2_IMI; wb_sel_d = WB_PC4; pc_sel_d = PC_ALU;
          end
          OPC_LUI, OPC_AUIPC: begin
            op2_sel_d = OP2_IMU; wb_sel_d = WB_ALU; pc_sel_d = PC_PLUS4;
          end
          default: begin
            // ECALL halts cleanly. Every other unknown encoding halts as
            // illegal.
            state_d   = S_HALT;
            halted_d  = 1'b1;
            illegal_d = (ir_q != ECALL_WORD);
          end
        endcase
      end

      S_EXEC: begin
        if (is_load || is_store) begin
          state_d   = S_MEM;
          mem_req_d = 1'b1;
          mem_we_d  = is_store;
        end else if (is_branch) begin
          state_d    = S_FETCH;
          inst_req_d = 1'b1;
        end else begin
          state_d   = S_WB;
          rf_we_d   = 1'b1;
          pc_we_d   = 1'b1;
          retire_d  = 1'b1;
          instret_d = instret_q + CNT_ONE;
        end
      end

      S_MEM: begin
        if (mem_ack) begin
          if (is_store) begin
            state_d    = S_FETCH;
            inst_req_d = 1'b1;
            pc_we_d    = 1'b1;
            pc_sel_d   = PC_PLUS4;
            retire_d   = 1'b1;
            instret_d  = instret_q + CNT_ONE;
          end else begin
            state_d   = S_WB;
            rf_we_d   = 1'b1;
            pc_we_d   = 1'b1;
            retire_d  = 1'b1;
            instret_d = instret_q + CNT_ONE;
          end
        end else if (wait_expired) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = is_store;
        end
      end

      S_WB: begin
        state_d    = S_FETCH;
        inst_req_d = 1'b1;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      inst_req_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      op2_sel_q  <= OP2_RS2;
      wb_sel_q   <= WB_ALU;
      pc_sel_q   <= PC_PLUS4;
      ir_q       <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      inst_req_q <= inst_req_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      rf_we_q    <= rf_we_d;
      pc_we_q    <= pc_we_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      op2_sel_q  <= op2_sel_d;
      wb_sel_q   <= wb_sel_d;
      pc_sel_q   <= pc_sel_d;
      ir_q       <= ir_d;
      instret_q  <= instret_d;
    end
  end

  assign inst_req = inst_req_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign rf_we    = rf_we_q;
  assign pc_we    = pc_we_q;
  assign retire   = retire_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign bus_err  = bus_err_q;
  assign op2_sel  = op2_sel_q;
  assign wb_sel   = wb_sel_q;
  assign pc_sel   = pc_sel_q;
  assign ir       = ir_q;
  assign instret  = instret_q;

endmodule
